// File: rtl/esn_rdout_unloader.sv
// esn_rdout_unloader
//
// Host-side consumer of the ESN readout results. On a rising edge of
// data_valid it snapshots the estimate and the eight learned weights. It then
// streams them toward the host bridge as one packet of 32-bit words on a
// valid/ready source interface.
//
// Word order (default build, 9 words):
//   index 0     : est
//   index 1 + k : weight k = W_out[32*k+31 : 32*k], k = 0..7
//
// Optional feature, macro ESN_UNLOAD_SEQHDR_EN:
//   Each packet is prefixed with the header {8'hA5, 8'd9, seq[15:0]}.
//   est and the weights move to indices 1..9, so a packet is 10 words.
//   seq counts captures, wraps at 0xFFFF and is cleared by reset.
//
// Ports:
//   clk        in   system clock
//   rst_N      in   asynchronous active-low reset
//   en         in   capture enable; a packet already in flight still completes
//   est        in   [31:0]  readout estimate
//   W_out      in   [255:0] learned weights
//   data_valid in   readout data-valid level
//   src_data   out  [31:0]  stream word
//   src_valid  out  src_data is valid
//   src_ready  in   downstream accepts the word
//   src_sop    out  first word of the packet
//   src_eop    out  last word of the packet
//   busy       out  a packet is held or in flight
//   drop_cnt   out  [15:0] saturating count of rising edges that were lost

module esn_rdout_unloader (
  input  logic         clk,
  input  logic         rst_N,
  input  logic         en,
  input  logic [31:0]  est,
  input  logic [255:0] W_out,
  input  logic         data_valid,
  output logic [31:0]  src_data,
  output logic         src_valid,
  input  logic         src_ready,
  output logic         src_sop,
  output logic         src_eop,
  output logic         busy,
  output logic [15:0]  drop_cnt
);

`ifdef ESN_UNLOAD_SEQHDR_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif

  // Index of the final word of a packet.
  localparam logic [3:0] LAST_IDX = 4'(8 + HDR_WORDS);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [31:0] snap_q [0:8];
  logic        dv_q;

`ifdef ESN_UNLOAD_SEQHDR_EN
  logic [15:0] seq_q;
`endif

  logic        rise;
  logic        last_acc;
  logic        can_take;
  logic        capture;
  logic        drop;
  logic [3:0]  nxt_idx;
  logic [31:0] nxt_word;
  logic [31:0] first_word;

  // Capture/drop decisions and selection of the next word to present.
  // A new packet may start either from IDLE or in the very cycle the final
  // word of the current packet is accepted, which is what lets back-to-back
  // packets run without an idle bubble. Word 0 is taken straight from the
  // inputs at capture time. Every later word comes from the snapshot, so the
  // inputs are free to change once a packet has started.
  always_comb begin
    rise     = data_valid & ~dv_q;
    last_acc = src_valid & src_ready & (idx_q == LAST_IDX);
    can_take = (state_q == IDLE) | last_acc;
    capture  = rise & en & can_take;
    drop     = rise & en & ~can_take;
    nxt_idx  = idx_q + 4'd1;

    nxt_word = '0;
    for (int i = 0; i < 9; i++) begin
      if (nxt_idx == 4'(i + HDR_WORDS)) begin
        nxt_word = snap_q[i];
      end
    end

`ifdef ESN_UNLOAD_SEQHDR_EN
    first_word = {8'hA5, 8'd9, seq_q};
`else
    first_word = est;
`endif
  end

  // Main sequencer. All stream outputs are registered, so src_ready only
  // steers state and never reaches an output combinationally. The async
  // reset drops src_valid at once and aborts any packet in flight without
  // issuing an end-of-packet.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      dv_q      <= 1'b0;
      drop_cnt  <= '0;
      src_data  <= '0;
      src_valid <= 1'b0;
      src_sop   <= 1'b0;
      src_eop   <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        snap_q[i] <= '0;
      end
`ifdef ESN_UNLOAD_SEQHDR_EN
      seq_q     <= '0;
`endif
    end else begin
      dv_q <= data_valid;

      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end

      if (capture) begin
        snap_q[0] <= est;
        for (int k = 0; k < 8; k++) begin
          snap_q[k + 1] <= W_out[32*k +: 32];
        end
        state_q   <= SEND;
        idx_q     <= '0;
        src_valid <= 1'b1;
        src_data  <= first_word;
        src_sop   <= 1'b1;
        src_eop   <= 1'b0;
`ifdef ESN_UNLOAD_SEQHDR_EN
        seq_q     <= seq_q + 16'd1;
`endif
      end else if ((state_q == SEND) && src_ready) begin
        if (idx_q == LAST_IDX) begin
          state_q   <= IDLE;
          idx_q     <= '0;
          src_valid <= 1'b0;
          src_data  <= '0;
          src_sop   <= 1'b0;
          src_eop   <= 1'b0;
        end else begin
          idx_q    <= nxt_idx;
          src_data <= nxt_word;
          src_sop  <= 1'b0;
          src_eop  <= (nxt_idx == LAST_IDX);
        end
      end
    end
  end

  assign busy = (state_q == SEND);

endmodule

// File: tb/tb_esn_rdout_unloader.sv
// Self-checking bench for esn_rdout_unloader. Inputs are driven on the falling
// clock edge and outputs are sampled on the falling edge, away from the
// active rising edge.

module tb_esn_rdout_unloader;

`ifdef ESN_UNLOAD_SEQHDR_EN
  localparam int NW = 10;
`else
  localparam int NW = 9;
`endif

  logic         clk;
  logic         rst_N;
  logic         en;
  logic [31:0]  est;
  logic [255:0] W_out;
  logic         data_valid;
  logic [31:0]  src_data;
  logic         src_valid;
  logic         src_ready;
  logic         src_sop;
  logic         src_eop;
  logic         busy;
  logic [15:0]  drop_cnt;

  int           checks;
  int           failures;
  logic [15:0]  exp_seq;
  logic [15:0]  pkt_seq;

  esn_rdout_unloader dut (
    .clk        (clk),
    .rst_N      (rst_N),
    .en         (en),
    .est        (est),
    .W_out      (W_out),
    .data_valid (data_valid),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_sop    (src_sop),
    .src_eop    (src_eop),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Expected word w of a packet whose estimate is e and sequence number s.
  // Weight k is always 0x20000000 + k in this bench.
  function automatic logic [31:0] exp_word(int w, logic [31:0] e, logic [15:0] s);
    int idx;
    idx = w;
`ifdef ESN_UNLOAD_SEQHDR_EN
    if (idx == 0) return {8'hA5, 8'd9, s};
    idx = idx - 1;
`else
    if (s == 16'hFFFF) idx = w;
`endif
    if (idx == 0) return e;
    return 32'h20000000 + 32'(idx - 1);
  endfunction

  // Stimulus only: present a rising edge of data_valid with a new estimate
  // that is expected to be captured at the next rising clock edge.
  task automatic start_capture(input logic [31:0] e);
    @(negedge clk);
    est        = e;
    data_valid = 1'b1;
    pkt_seq    = exp_seq;
    exp_seq    = exp_seq + 16'd1;
  endtask

  task automatic test_reset();
    rst_N      = 1'b0;
    en         = 1'b1;
    src_ready  = 1'b0;
    data_valid = 1'b0;
    est        = '0;
    exp_seq    = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({src_valid, src_sop, src_eop, busy, src_data, drop_cnt} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_state got v=%b sop=%b eop=%b busy=%b data=%h drop=%h want all zero",
               src_valid, src_sop, src_eop, busy, src_data, drop_cnt);
    end
    rst_N = 1'b1;
    @(negedge clk);
    checks++;
    if ({src_valid, busy} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_release got v=%b busy=%b want 0 0", src_valid, busy);
    end
  endtask

  task automatic test_single();
    src_ready = 1'b1;
    start_capture(32'h11111111);
    for (int w = 0; w < NW; w++) begin
      @(negedge clk);
      data_valid = 1'b0;
      checks++;
      if ({src_valid, busy, src_sop, src_eop, src_data} !==
          {1'b1, 1'b1, (w == 0), (w == NW - 1), exp_word(w, 32'h11111111, pkt_seq)}) begin
        failures++;
        $display("[TB] FAIL single_word%0d got v=%b busy=%b sop=%b eop=%b data=%h want 1 1 %b %b %h",
                 w, src_valid, busy, src_sop, src_eop, src_data,
                 (w == 0), (w == NW - 1), exp_word(w, 32'h11111111, pkt_seq));
      end
    end
    @(negedge clk);
    checks++;
    if ({src_valid, busy, src_sop, src_eop} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL single_idle got v=%b busy=%b sop=%b eop=%b want 0 0 0 0",
               src_valid, busy, src_sop, src_eop);
    end
  endtask

  task automatic test_backpressure();
    int          w;
    int          cyc;
    logic        stalled;
    logic [31:0] held;
    w       = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    start_capture(32'h11111111);
    src_ready = 1'b0;
    while ((w < NW) && (cyc < 60)) begin
      @(negedge clk);
      data_valid = 1'b0;
      cyc++;
      checks++;
      if ({src_valid, src_sop, src_eop, src_data} !==
          {1'b1, (w == 0), (w == NW - 1), exp_word(w, 32'h11111111, pkt_seq)}) begin
        failures++;
        $display("[TB] FAIL bp_word%0d got v=%b sop=%b eop=%b data=%h want 1 %b %b %h",
                 w, src_valid, src_sop, src_eop, src_data,
                 (w == 0), (w == NW - 1), exp_word(w, 32'h11111111, pkt_seq));
      end
      if (stalled) begin
        checks++;
        if (src_data !== held) begin
          failures++;
          $display("[TB] FAIL bp_stable got data=%h want held %h", src_data, held);
        end
      end
      src_ready = cyc[0];
      stalled   = ~src_ready;
      held      = src_data;
      if (src_ready) w++;
    end
    checks++;
    if (w != NW) begin
      failures++;
      $display("[TB] FAIL bp_budget got %0d words want %0d", w, NW);
    end
    @(negedge clk);
    checks++;
    if ({src_valid, busy} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL bp_idle got v=%b busy=%b want 0 0", src_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] first_seq;
    src_ready = 1'b1;
    start_capture(32'h55555555);
    first_seq = pkt_seq;
    for (int w = 0; w < NW; w++) begin
      @(negedge clk);
      data_valid = 1'b0;
      checks++;
      if ({src_valid, src_sop, src_eop, src_data} !==
          {1'b1, (w == 0), (w == NW - 1), exp_word(w, 32'h55555555, first_seq)}) begin
        failures++;
        $display("[TB] FAIL b2b_first_word%0d got v=%b sop=%b eop=%b data=%h want 1 %b %b %h",
                 w, src_valid, src_sop, src_eop, src_data,
                 (w == 0), (w == NW - 1), exp_word(w, 32'h55555555, first_seq));
      end
    end
    // Rising edge coincides with acceptance of the last word.
    est        = 32'h66666666;
    data_valid = 1'b1;
    pkt_seq    = exp_seq;
    exp_seq    = exp_seq + 16'd1;
    for (int w = 0; w < NW; w++) begin
      @(negedge clk);
      data_valid = 1'b0;
      checks++;
      if ({src_valid, src_sop, src_eop, src_data} !==
          {1'b1, (w == 0), (w == NW - 1), exp_word(w, 32'h66666666, pkt_seq)}) begin
        failures++;
        $display("[TB] FAIL b2b_second_word%0d got v=%b sop=%b eop=%b data=%h want 1 %b %b %h",
                 w, src_valid, src_sop, src_eop, src_data,
                 (w == 0), (w == NW - 1), exp_word(w, 32'h66666666, pkt_seq));
      end
    end
    checks++;
    if (drop_cnt !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL b2b_drop got %h want 0000", drop_cnt);
    end
    @(negedge clk);
    checks++;
    if (src_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_idle got v=%b want 0", src_valid);
    end
  endtask

  task automatic test_drop();
    src_ready = 1'b0;
    start_capture(32'h44444444);
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      data_valid = 1'b0;
      @(negedge clk);
      est        = 32'hDEAD0000 + 32'(e);
      data_valid = 1'b1;
    end
    @(negedge clk);
    data_valid = 1'b0;
    checks++;
    if (drop_cnt !== 16'd3) begin
      failures++;
      $display("[TB] FAIL drop_count got %h want 0003", drop_cnt);
    end
    src_ready = 1'b1;
    for (int w = 0; w < NW; w++) begin
      checks++;
      if ({src_valid, src_sop, src_eop, src_data} !==
          {1'b1, (w == 0), (w == NW - 1), exp_word(w, 32'h44444444, pkt_seq)}) begin
        failures++;
        $display("[TB] FAIL drop_word%0d got v=%b sop=%b eop=%b data=%h want 1 %b %b %h",
                 w, src_valid, src_sop, src_eop, src_data,
                 (w == 0), (w == NW - 1), exp_word(w, 32'h44444444, pkt_seq));
      end
      @(negedge clk);
    end
    checks++;
    if (src_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL drop_idle got v=%b want 0", src_valid);
    end
  endtask

  task automatic test_saturation();
    src_ready = 1'b0;
    start_capture(32'h12345678);
    @(negedge clk);
    data_valid = 1'b0;
    force dut.drop_cnt = 16'hFFFE;
    #1;
    release dut.drop_cnt;
    @(negedge clk);
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    checks++;
    if (drop_cnt !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL sat_reach got %h want ffff", drop_cnt);
    end
    @(negedge clk);
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    checks++;
    if (drop_cnt !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL sat_hold got %h want ffff", drop_cnt);
    end
    src_ready = 1'b1;
    repeat (NW) @(negedge clk);
    checks++;
    if (src_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sat_idle got v=%b want 0", src_valid);
    end
  endtask

  task automatic test_enable_reset();
    @(negedge clk);
    rst_N = 1'b0;
    @(negedge clk);
    rst_N   = 1'b1;
    exp_seq = '0;
    checks++;
    if (drop_cnt !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL en_reset_drop got %h want 0000", drop_cnt);
    end
    en         = 1'b0;
    est        = 32'h99999999;
    data_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({src_valid, busy} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL en_low_idle got v=%b busy=%b want 0 0", src_valid, busy);
      end
    end
    data_valid = 1'b0;
    en         = 1'b1;
    checks++;
    if (drop_cnt !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL en_low_drop got %h want 0000", drop_cnt);
    end

    src_ready = 1'b1;
    start_capture(32'h77777777);
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      data_valid = 1'b0;
      checks++;
      if ({src_valid, src_sop, src_data} !==
          {1'b1, (w == 0), exp_word(w, 32'h77777777, pkt_seq)}) begin
        failures++;
        $display("[TB] FAIL abort_word%0d got v=%b sop=%b data=%h want 1 %b %h",
                 w, src_valid, src_sop, src_data, (w == 0), exp_word(w, 32'h77777777, pkt_seq));
      end
    end
    rst_N = 1'b0;
    #1;
    checks++;
    if ({src_valid, src_eop, busy} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL abort_async got v=%b eop=%b busy=%b want 0 0 0", src_valid, src_eop, busy);
    end
    @(negedge clk);
    rst_N   = 1'b1;
    exp_seq = '0;

    start_capture(32'h88888888);
    for (int w = 0; w < NW; w++) begin
      @(negedge clk);
      data_valid = 1'b0;
      checks++;
      if ({src_valid, src_sop, src_eop, src_data} !==
          {1'b1, (w == 0), (w == NW - 1), exp_word(w, 32'h88888888, pkt_seq)}) begin
        failures++;
        $display("[TB] FAIL clean_word%0d got v=%b sop=%b eop=%b data=%h want 1 %b %b %h",
                 w, src_valid, src_sop, src_eop, src_data,
                 (w == 0), (w == NW - 1), exp_word(w, 32'h88888888, pkt_seq));
      end
    end
  endtask

`ifdef ESN_UNLOAD_SEQHDR_EN
  task automatic test_seq_header();
    logic [31:0] hdr_exp [0:1];
    hdr_exp[0] = 32'hA5090000;
    hdr_exp[1] = 32'hA5090001;
    @(negedge clk);
    rst_N = 1'b0;
    @(negedge clk);
    rst_N     = 1'b1;
    exp_seq   = '0;
    src_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      start_capture(32'hC0DE0000 + 32'(p));
      for (int w = 0; w < NW; w++) begin
        @(negedge clk);
        data_valid = 1'b0;
        if (w == 0) begin
          checks++;
          if (src_data !== hdr_exp[p]) begin
            failures++;
            $display("[TB] FAIL hdr_pkt%0d got %h want %h", p, src_data, hdr_exp[p]);
          end
        end
        checks++;
        if (src_eop !== (w == 9)) begin
          failures++;
          $display("[TB] FAIL hdr_eop_pkt%0d_word%0d got %b want %b", p, w, src_eop, (w == 9));
        end
      end
      @(negedge clk);
    end
  endtask
`endif

  // Scenario sequence.
  initial begin
    checks   = 0;
    failures = 0;
    pkt_seq  = '0;
    W_out    = '0;
    for (int k = 0; k < 8; k++) begin
      W_out[32*k +: 32] = 32'h20000000 + 32'(k);
    end
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_drop();
    test_saturation();
    test_enable_reset();
`ifdef ESN_UNLOAD_SEQHDR_EN
    test_seq_header();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
